tmds_rx_channel: RTL and testbench



---
 rtl/tmds_pkg.sv | 21 ++
 rtl/tmds_symbol_decoder.sv | 44 ++++
 rtl/tmds_rx_channel.sv | 193 +++++++++++++++++++
 tb/tb_tmds_rx_channel.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions.
//   - SYM_W / HALF_W: 10-bit TMDS symbol carried as two 5-bit deserializer words
//   - TOKEN_Cxy: the four control-token code words, named by the {c1,c0} they carry
//   - rx_state_e: symbol-alignment state (SEARCH, LOCKED)
package tmds_pkg;

    localparam int SYM_W  = 10;
    localparam int HALF_W = 5;

    // Control tokens; the suffix is the {c1,c0} code each one decodes to.
    localparam logic [SYM_W-1:0] TOKEN_C00 = 10'h354;
    localparam logic [SYM_W-1:0] TOKEN_C01 = 10'h0AB;
    localparam logic [SYM_W-1:0] TOKEN_C10 = 10'h154;
    localparam logic [SYM_W-1:0] TOKEN_C11 = 10'h2AB;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } rx_state_e;

endpackage

// File: rtl/tmds_symbol_decoder.sv
// Combinational TMDS 10b symbol decoder, shared by the video path and a
// future TERC4 path.
// Ports:
//   symbol_i   [9:0]  raw aligned symbol
//   data_en_o         1 = data symbol, 0 = control token
//   pixel_o    [7:0]  decoded byte, 0 for control tokens
//   ctrl_o     [1:0]  {c1,c0} for control tokens, 0 for data
//   is_token_o        symbol is one of the four control tokens
module tmds_symbol_decoder
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0] symbol_i,
    output logic             data_en_o,
    output logic [7:0]       pixel_o,
    output logic [1:0]       ctrl_o,
    output logic             is_token_o
);

    logic [7:0] d;
    logic [7:0] data_pix;

    // Bit 9 flags an inverted payload; bit 8 selects XOR (1) or XNOR (0) chaining.
    assign d        = symbol_i[9] ? ~symbol_i[7:0] : symbol_i[7:0];
    assign data_pix = {d[7:1] ^ d[6:0] ^ {7{~symbol_i[8]}}, d[0]};

    always_comb begin
        data_en_o  = 1'b0;
        pixel_o    = 8'h00;
        ctrl_o     = 2'b00;
        is_token_o = 1'b1;
        case (symbol_i)
            TOKEN_C00: ctrl_o = 2'b00;
            TOKEN_C01: ctrl_o = 2'b01;
            TOKEN_C10: ctrl_o = 2'b10;
            TOKEN_C11: ctrl_o = 2'b11;
            default: begin
                is_token_o = 1'b0;
                data_en_o  = 1'b1;
                pixel_o    = data_pix;
            end
        endcase
    end

endmodule

// File: rtl/tmds_rx_channel.sv
// One TMDS receive channel: word-pair history, symbol alignment hunt on
// control tokens, and symbol decode.
// Parameters: TOKEN_RUN, SEARCH_TIMEOUT, LOCK_TIMEOUT.
// Ports:
//   dataLoadClock       deserializer word clock, all logic on rising edge
//   asyncResetN         asynchronous active-low reset
//   serialData  [4:0]   deserialized word, bit 0 received first
//   symbolValid         one-cycle strobe for the decoded outputs
//   dataEnable          1 = data symbol, 0 = control token
//   pixelData   [7:0]   decoded byte, 0 on control tokens
//   ctrl        [1:0]   {c1,c0} of the last control token seen while locked
//   locked              symbol alignment established
//   bitOffset   [3:0]   current alignment offset, 0..9
//   errorCount  [15:0]  lock-loss count
// Build option: define TMDS_RX_ERROR_COUNT_EN to count LOCKED->SEARCH
// transitions (saturating); otherwise errorCount is tied to 0.
//
// state  | meaning
// SEARCH | hunting for TOKEN_RUN consecutive tokens at bitOffset
// LOCKED | aligned; decoded symbols are strobed out
module tmds_rx_channel
    import tmds_pkg::*;
#(
    parameter int TOKEN_RUN      = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic              dataLoadClock,
    input  logic              asyncResetN,
    input  logic [HALF_W-1:0] serialData,
    output logic              symbolValid,
    output logic              dataEnable,
    output logic [7:0]        pixelData,
    output logic [1:0]        ctrl,
    output logic              locked,
    output logic [3:0]        bitOffset,
    output logic [15:0]       errorCount
);

    localparam int RUN_W  = $clog2(TOKEN_RUN) + 1;
    localparam int TMO_W  = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int IDLE_W = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [RUN_W-1:0]  RUN_LIMIT  = RUN_W'(TOKEN_RUN);
    localparam logic [TMO_W-1:0]  TMO_LIMIT  = TMO_W'(SEARCH_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(LOCK_TIMEOUT);
    localparam logic [3:0]        OFFSET_MAX = 4'(SYM_W - 1);

    rx_state_e              state_q;
    logic [2*SYM_W-1:0]     history_q;
    logic [2*SYM_W+HALF_W-1:0] hist_ext;
    logic [SYM_W-1:0]       window;
    logic                   phase_q;
    logic                   raw_valid_q;
    logic [SYM_W-1:0]       raw_q;
    logic [3:0]             bit_off_q;
    logic [RUN_W-1:0]       run_q, run_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic                   valid_q, de_q, locked_q;
    logic [7:0]             pix_q;
    logic [1:0]             ctrl_q;

    logic                   dec_de, dec_tok;
    logic [7:0]             dec_pix;
    logic [1:0]             dec_ctrl;
    logic                   lock_hit, tmo_hit, idle_hit;

    // Zero-extend so the 4-bit offset can never select past the history.
    assign hist_ext = {{HALF_W{1'b0}}, history_q};
    assign window   = hist_ext[bit_off_q +: SYM_W];

    tmds_symbol_decoder u_decoder (
        .symbol_i   (raw_q),
        .data_en_o  (dec_de),
        .pixel_o    (dec_pix),
        .ctrl_o     (dec_ctrl),
        .is_token_o (dec_tok)
    );

    // Saturating next values; only consumed on symbol-evaluation edges.
    always_comb begin
        run_d  = '0;
        idle_d = '0;
        if (dec_tok)
            run_d = (&run_q) ? run_q : run_q + 1'b1;
        else
            idle_d = (&idle_q) ? idle_q : idle_q + 1'b1;
        tmo_d = (&tmo_q) ? tmo_q : tmo_q + 1'b1;
    end

    assign lock_hit = (run_d == RUN_LIMIT);
    assign tmo_hit  = (tmo_d == TMO_LIMIT);
    assign idle_hit = (idle_d == IDLE_LIMIT);

    always_ff @(posedge dataLoadClock or negedge asyncResetN) begin
        if (!asyncResetN) begin
            state_q     <= SEARCH;
            history_q   <= '0;
            phase_q     <= 1'b0;
            raw_valid_q <= 1'b0;
            raw_q       <= '0;
            bit_off_q   <= '0;
            run_q       <= '0;
            tmo_q       <= '0;
            idle_q      <= '0;
            valid_q     <= 1'b0;
            de_q        <= 1'b0;
            pix_q       <= '0;
            ctrl_q      <= '0;
            locked_q    <= 1'b0;
        end else begin
            history_q   <= {serialData, history_q[2*SYM_W-1:HALF_W]};
            phase_q     <= ~phase_q;
            raw_valid_q <= phase_q;
            valid_q     <= 1'b0;
            if (phase_q)
                raw_q <= window;

            // Evaluation edges alternate with capture edges, so bitOffset
            // never changes under a capture.
            if (raw_valid_q) begin
                case (state_q)
                    SEARCH: begin
                        if (lock_hit) begin
                            // Lock wins over a coincident timeout; this symbol is strobed.
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                            run_q    <= '0;
                            tmo_q    <= '0;
                            idle_q   <= '0;
                            valid_q  <= 1'b1;
                            de_q     <= dec_de;
                            pix_q    <= dec_pix;
                            if (dec_tok)
                                ctrl_q <= dec_ctrl;
                        end else if (tmo_hit) begin
                            bit_off_q <= (bit_off_q == OFFSET_MAX) ? 4'd0 : bit_off_q + 4'd1;
                            run_q     <= '0;
                            tmo_q     <= '0;
                        end else begin
                            run_q <= run_d;
                            tmo_q <= tmo_d;
                        end
                    end
                    LOCKED: begin
                        if (idle_hit) begin
                            state_q  <= SEARCH;
                            locked_q <= 1'b0;
                            run_q    <= '0;
                            tmo_q    <= '0;
                            idle_q   <= '0;
                        end else begin
                            idle_q  <= idle_d;
                            valid_q <= 1'b1;
                            de_q    <= dec_de;
                            pix_q   <= dec_pix;
                            if (dec_tok)
                                ctrl_q <= dec_ctrl;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

`ifdef TMDS_RX_ERROR_COUNT_EN
    logic        lock_drop;
    logic [15:0] err_q;

    assign lock_drop = raw_valid_q && (state_q == LOCKED) && idle_hit;

    always_ff @(posedge dataLoadClock or negedge asyncResetN) begin
        if (!asyncResetN)
            err_q <= '0;
        else if (lock_drop && (err_q != 16'hFFFF))
            err_q <= err_q + 16'd1;
    end

    assign errorCount = err_q;
`else
    assign errorCount = 16'h0000;
`endif

    assign symbolValid = valid_q;
    assign dataEnable  = de_q;
    assign pixelData   = pix_q;
    assign ctrl        = ctrl_q;
    assign locked      = locked_q;
    assign bitOffset   = bit_off_q;

endmodule

// File: tb/tb_tmds_rx_channel.sv
module tb_tmds_rx_channel;

    localparam int TOKEN_RUN      = 8;
    localparam int SEARCH_TIMEOUT = 2048;
    localparam int LOCK_TIMEOUT   = 4096;
`ifdef TMDS_RX_ERROR_COUNT_EN
    localparam int EXP_ERR_AFTER_DROP = 1;
`else
    localparam int EXP_ERR_AFTER_DROP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  sdata = 5'd0;
    logic        symbolValid, dataEnable, locked;
    logic [7:0]  pixelData;
    logic [1:0]  ctrl;
    logic [3:0]  bitOffset;
    logic [15:0] errorCount;

    tmds_rx_channel #(
        .TOKEN_RUN      (TOKEN_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT)
    ) dut (
        .dataLoadClock (clk),
        .asyncResetN   (rst_n),
        .serialData    (sdata),
        .symbolValid   (symbolValid),
        .dataEnable    (dataEnable),
        .pixelData     (pixelData),
        .ctrl          (ctrl),
        .locked        (locked),
        .bitOffset     (bitOffset),
        .errorCount    (errorCount)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus bit stream, oldest bit at the front.
    bit sq[$];

    // Reference model: last 20 received bits (index 0 oldest), edge count
    // since reset, pending captured symbol and the expected outputs.
    bit          m_q[$];
    int          m_edges;
    bit          m_pending;
    int          m_sym, m_run, m_tmo, m_idle;
    logic        e_valid, e_de, e_locked;
    logic [7:0]  e_pix;
    logic [1:0]  e_ctrl;
    logic [3:0]  e_off;
    logic [15:0] e_err;

    // Payload of the most recent strobe seen on the DUT.
    logic        l_de;
    logic [7:0]  l_pix;
    logic [1:0]  l_ctrl;

    function automatic logic [32:0] dut_vec();
        return {symbolValid, dataEnable, pixelData, ctrl, locked, bitOffset, errorCount};
    endfunction

    function automatic logic [32:0] exp_vec();
        return {e_valid, e_de, e_pix, e_ctrl, e_locked, e_off, e_err};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decode straight from the token table and bitwise chaining rules.
    function automatic void ref_decode(input int s, output bit tok, output bit de,
                                       output int pix, output int c);
        int d;
        tok = 1'b1; de = 1'b0; pix = 0; c = 0;
        case (s)
            'h354: c = 0;
            'h0AB: c = 1;
            'h154: c = 2;
            'h2AB: c = 3;
            default: begin
                tok = 1'b0;
                de  = 1'b1;
                d   = ((s >> 9) & 1) != 0 ? (~s) & 255 : s & 255;
                pix = d & 1;
                for (int i = 1; i < 8; i++) begin
                    int x;
                    x = ((d >> i) ^ (d >> (i - 1))) & 1;
                    if (((s >> 8) & 1) == 0) x = 1 - x;
                    pix += x << i;
                end
            end
        endcase
    endfunction

    function automatic bit is_token(input int s);
        return s == 'h354 || s == 'h0AB || s == 'h154 || s == 'h2AB;
    endfunction

    task automatic model_reset();
        m_q.delete();
        repeat (20) m_q.push_back(1'b0);
        m_edges = 0; m_pending = 1'b0; m_sym = 0;
        m_run = 0; m_tmo = 0; m_idle = 0;
        e_valid = 0; e_de = 0; e_pix = 0; e_ctrl = 0;
        e_locked = 0; e_off = 0; e_err = 0;
    endtask

    task automatic model_emit(input bit tok, input bit de, input int pix, input int c);
        e_valid = 1'b1;
        e_de    = de;
        e_pix   = 8'(pix);
        if (tok) e_ctrl = 2'(c);
    endtask

    task automatic model_edge(input logic [4:0] w);
        bit cap;
        int cap_sym;
        bit tok, de;
        int pix, c;
        cap = (m_edges % 2) == 1;
        cap_sym = 0;
        if (cap)
            for (int j = 0; j < 10; j++) cap_sym |= int'(m_q[e_off + j]) << j;
        e_valid = 1'b0;
        if (m_pending) begin
            ref_decode(m_sym, tok, de, pix, c);
            if (!e_locked) begin
                m_run = tok ? m_run + 1 : 0;
                m_tmo = m_tmo + 1;
                if (m_run == TOKEN_RUN) begin
                    e_locked = 1'b1;
                    m_run = 0; m_tmo = 0; m_idle = 0;
                    model_emit(tok, de, pix, c);
                end else if (m_tmo == SEARCH_TIMEOUT) begin
                    e_off = (e_off == 4'd9) ? 4'd0 : e_off + 4'd1;
                    m_run = 0; m_tmo = 0;
                end
            end else begin
                m_idle = tok ? 0 : m_idle + 1;
                if (m_idle == LOCK_TIMEOUT) begin
                    e_locked = 1'b0;
                    m_run = 0; m_tmo = 0; m_idle = 0;
`ifdef TMDS_RX_ERROR_COUNT_EN
                    if (e_err != 16'hFFFF) e_err = e_err + 16'd1;
`endif
                end else begin
                    model_emit(tok, de, pix, c);
                end
            end
        end
        m_pending = cap;
        if (cap) m_sym = cap_sym;
        for (int j = 0; j < 5; j++) begin
            m_q.push_back(w[j]);
            void'(m_q.pop_front());
        end
        m_edges++;
    endtask

    task automatic cycle(input logic [4:0] w);
        sdata = w;
        @(posedge clk);
        model_edge(w);
        #1;
        if (symbolValid === 1'b1) begin
            l_de = dataEnable; l_pix = pixelData; l_ctrl = ctrl;
        end
        chk("cycle_outputs", 64'(dut_vec()), 64'(exp_vec()));
    endtask

    task automatic flush();
        logic [4:0] w;
        while (sq.size() >= 5) begin
            for (int j = 0; j < 5; j++) w[j] = sq.pop_front();
            cycle(w);
        end
    endtask

    task automatic push_zeros(input int n);
        repeat (n) sq.push_back(1'b0);
        flush();
    endtask

    task automatic send(input logic [9:0] s);
        for (int j = 0; j < 10; j++) sq.push_back(s[j]);
        flush();
    endtask

    function automatic logic [9:0] rand_data();
        int s;
        do s = $urandom_range(0, 1023); while (is_token(s));
        return 10'(s);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sq.delete();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] toks [4];
        toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;

        do_reset();
        chk("reset_outputs", 64'(dut_vec()), 64'(0));

        // A 5-bit lead places every symbol on the offset-0 window.
        push_zeros(5);
        repeat (TOKEN_RUN) send(10'h354);
        repeat (2) send(10'h354);
        chk("lock_locked", 64'(locked), 64'(1));
        chk("lock_offset", 64'(bitOffset), 64'(0));
        chk("lock_ctrl", 64'(ctrl), 64'(0));
        chk("lock_dataenable", 64'(dataEnable), 64'(0));

        send(10'h1FF); send(10'h354); send(10'h354);
        chk("data_1ff_pixel", 64'(l_pix), 64'(8'h01));
        chk("data_1ff_de", 64'(l_de), 64'(1));

        send(10'h2AB); send(10'h354); send(10'h354);
        chk("token_2ab_ctrl", 64'(l_ctrl), 64'(2'b11));
        chk("token_2ab_pixel", 64'(l_pix), 64'(0));
        chk("token_2ab_de", 64'(l_de), 64'(0));

        repeat (300) begin
            if ($urandom_range(0, 1) == 1) send(toks[$urandom_range(0, 3)]);
            else send(10'($urandom_range(0, 1023)));
        end
        chk("random_still_locked", 64'(locked), 64'(1));

        repeat (LOCK_TIMEOUT + 4) send(rand_data());
        chk("idle_unlocked", 64'(locked), 64'(0));
        chk("idle_errorcount", 64'(errorCount), 64'(EXP_ERR_AFTER_DROP));

        repeat (TOKEN_RUN + 2) send(10'h354);
        chk("relock_locked", 64'(locked), 64'(1));
        send(10'h1FF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'(dut_vec()), 64'(0));
        do_reset();

        push_zeros(5);
        repeat (TOKEN_RUN - 1) send(10'h354);
        repeat (3) send(10'h1FF);
        chk("short_run_no_lock", 64'(locked), 64'(0));
        repeat (TOKEN_RUN + 2) send(10'h354);
        chk("post_reset_relock", 64'(locked), 64'(1));

        // Token stream delayed by 3 bits relative to the offset-0 alignment.
        do_reset();
        push_zeros(8);
        repeat (3 * SEARCH_TIMEOUT + 20) send(10'h354);
        chk("shift3_locked", 64'(locked), 64'(1));
        chk("shift3_offset", 64'(bitOffset), 64'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
